// File: rtl/iram_loader_if.sv
// Loader bus: UART byte stream in, IRAM write port and load status out.
// The master drives the byte stream; the slave (the loader) drives the rest.
interface iram_loader_if #(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8
);
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic [IRAM_ADDR_BITS-1:0] iram_wa;
    logic                      iram_wen;
    logic [WIDTH-1:0]          iram_din;
    logic                      cpu_hold;
    logic                      load_done;
    logic                      load_err;
    logic [IRAM_ADDR_BITS:0]   words_loaded;

    modport master (
        output rx_data, rx_valid,
        input  iram_wa, iram_wen, iram_din, cpu_hold, load_done, load_err, words_loaded
    );

    modport slave (
        input  rx_data, rx_valid,
        output iram_wa, iram_wen, iram_din, cpu_hold, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/iram_loader.sv
// Byte-stream program loader: SYNC / LEN / payload / CSUM framing, big-endian
// word assembly, registered IRAM writes from address 0, CPU hold during load.
module iram_loader #(
    parameter int         WIDTH          = 16,
    parameter int         IRAM_ADDR_BITS = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    iram_loader_if.slave bus
);
    localparam int BPW = WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int GW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] BCNT_LAST = BCW'(BPW - 1);
    localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_ONE   = GW'(1);
    localparam logic [31:0]    DEPTH     = 32'(1) << IRAM_ADDR_BITS;
    localparam logic [IRAM_ADDR_BITS:0] WORD_ONE = (IRAM_ADDR_BITS+1)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_CSUM = 2'd3;

    logic [1:0]                state_q,  state_d;
    logic [BCW-1:0]            bcnt_q,   bcnt_d;
    logic [WIDTH-1:0]          word_q,   word_d;
    logic [7:0]                csum_q,   csum_d;
    logic [7:0]                len_q,    len_d;
    logic [GW-1:0]             gap_q,    gap_d;
    logic                      wen_q,    wen_d;
    logic [IRAM_ADDR_BITS-1:0] wa_q,     wa_d;
    logic [WIDTH-1:0]          din_q,    din_d;
    logic                      hold_q,   hold_d;
    logic                      done_q,   done_d;
    logic                      err_q,    err_d;
    logic [IRAM_ADDR_BITS:0]   words_q,  words_d;

    // Word so far with the incoming byte shifted in at the LS end (MS byte arrives first).
    logic [WIDTH-1:0] asm_word;
    assign asm_word = (word_q << 8) | WIDTH'(bus.rx_data);

    // words_q counts words already written, so it is also the index of the word in flight.
    logic last_byte, last_word, len_ovf;
    assign last_byte = (bcnt_q == BCNT_LAST);
    assign last_word = (32'(words_q) == 32'(len_q));
    assign len_ovf   = (32'(bus.rx_data) + 32'd1) > DEPTH;

    // Frame parser, word assembler, checksum and inter-byte timeout.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        len_d   = len_q;
        gap_d   = gap_q;
        wen_d   = 1'b0;
        wa_d    = wa_q;
        din_d   = din_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        words_d = words_q;

        if (state_q == S_IDLE) begin
            gap_d = '0;
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                state_d = S_LEN;
                hold_d  = 1'b1;
                err_d   = 1'b0;
                words_d = '0;
                csum_d  = '0;
                bcnt_d  = '0;
            end
        end else if (bus.rx_valid) begin
            gap_d = '0;
            if (state_q == S_LEN) begin
                len_d = bus.rx_data;
                if (len_ovf) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    csum_d  = csum_q ^ bus.rx_data;
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
            end else if (state_q == S_DATA) begin
                csum_d = csum_q ^ bus.rx_data;
                word_d = asm_word;
                if (last_byte) begin
                    // Registered write: the pulse appears on the following cycle.
                    bcnt_d  = '0;
                    wen_d   = 1'b1;
                    wa_d    = words_q[IRAM_ADDR_BITS-1:0];
                    din_d   = asm_word;
                    words_d = words_q + WORD_ONE;
                    if (last_word)
                        state_d = S_CSUM;
                end else begin
                    bcnt_d = bcnt_q + BCNT_ONE;
                end
            end else begin
                // CSUM byte: success releases the CPU, failure leaves it held.
                if (bus.rx_data == csum_q) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
        end else if (gap_q == GAP_LAST) begin
            // Line went quiet mid-frame: abort and keep the CPU held.
            err_d   = 1'b1;
            gap_d   = '0;
            state_d = S_IDLE;
        end else begin
            gap_d = gap_q + GAP_ONE;
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            wen_q   <= 1'b0;
            wa_q    <= '0;
            din_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            wen_q   <= wen_d;
            wa_q    <= wa_d;
            din_q   <= din_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    assign bus.iram_wa      = wa_q;
    assign bus.iram_wen     = wen_q;
    assign bus.iram_din     = din_q;
    assign bus.cpu_hold     = hold_q;
    assign bus.load_done    = done_q;
    assign bus.load_err     = err_q;
    assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: directed frames, expected writes/completions queued
// at stimulus time and matched by an independent output monitor.
module tb_iram_loader;
    localparam int AB = 4;
    localparam int W  = 16;

    logic clk;
    logic reset;

    iram_loader_if #(.WIDTH(W), .IRAM_ADDR_BITS(AB)) bus ();

    iram_loader #(
        .WIDTH(W), .IRAM_ADDR_BITS(AB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0] wa;
        logic [W-1:0]  din;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_done[$];
    logic [7:0] fr[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive the bytes in fr; returns on the first negedge after the last strobe was sampled.
    task automatic send_frame(input bit b2b);
        foreach (fr[i]) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = fr[i];
            if (!b2b) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
            end
        end
        if (b2b) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic push_good1();
        exp_wr.push_back('{wa: 4'd0, din: 16'h1234});
        exp_wr.push_back('{wa: 4'd1, din: 16'hABCD});
        exp_done.push_back(2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic hold, input logic err, input int words);
        chk({tag, "_hold"},  32'(bus.cpu_hold), 32'(hold));
        chk({tag, "_err"},   32'(bus.load_err), 32'(err));
        chk({tag, "_words"}, 32'(bus.words_loaded), 32'(words));
    endtask

    // Monitor: every write pulse and completion pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.iram_wen && bus.load_done)
                chk("wen_done_overlap", 32'd1, 32'd0);
            if (bus.iram_wen) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wen", 32'(bus.iram_wa), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.iram_wa), 32'(e.wa));
                    chk("wr_data", 32'(bus.iram_din), 32'(e.din));
                end
            end
            if (bus.load_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    int nw;
                    nw = exp_done.pop_front();
                    chk("done_words", 32'(bus.words_loaded), 32'(nw));
                    chk("done_hold", 32'(bus.cpu_hold), 32'd0);
                    chk("done_err", 32'(bus.load_err), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        #2 reset = 1'b0;
        #3;
        chk("rst_wen",  32'(bus.iram_wen), 32'd0);
        chk("rst_wa",   32'(bus.iram_wa),  32'd0);
        chk("rst_din",  32'(bus.iram_din), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk_status("rst", 1'b0, 1'b0, 0);
        idle(2);
        reset = 1'b1;
        idle(2);

        // 1: good load
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        push_good1();
        send_frame(1'b0);
        chk("t1_done_pulse", 32'(bus.load_done), 32'd1);
        idle(1);
        chk("t1_done_single", 32'(bus.load_done), 32'd0);
        idle(2);
        chk_status("t1", 1'b0, 1'b0, 2);

        // 2: bad checksum, then recovery
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        exp_wr.push_back('{wa: 4'd0, din: 16'h1234});
        exp_wr.push_back('{wa: 4'd1, din: 16'hABCD});
        send_frame(1'b0);
        idle(3);
        chk_status("t2_bad", 1'b1, 1'b1, 2);
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        push_good1();
        send_frame(1'b0);
        idle(3);
        chk_status("t2_good", 1'b0, 1'b0, 2);

        // 3: non-sync bytes ignored in IDLE, back-to-back frame, sync byte as payload
        fr = '{8'h00, 8'hFF, 8'h5A};
        send_frame(1'b1);
        idle(2);
        chk_status("t3_ignored", 1'b0, 1'b0, 2);
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        push_good1();
        send_frame(1'b1);
        chk("t3_done_pulse", 32'(bus.load_done), 32'd1);
        idle(3);
        chk_status("t3_b2b", 1'b0, 1'b0, 2);
        fr = '{8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00};
        exp_wr.push_back('{wa: 4'd0, din: 16'hA5A5});
        exp_done.push_back(1);
        send_frame(1'b1);
        idle(3);
        chk_status("t3_a5", 1'b0, 1'b0, 1);

        // 4: timeout 100 cycles after the last strobe, no write issued
        fr = '{8'hA5, 8'h01, 8'h12};
        send_frame(1'b0);
        idle(99);
        chk("t4_err_early", 32'(bus.load_err), 32'd0);
        idle(1);
        chk("t4_err_at_100", 32'(bus.load_err), 32'd1);
        chk_status("t4", 1'b1, 1'b1, 0);

        // 5: length overflow (N=17 > 16); back in IDLE so A5 clears err first
        fr = '{8'hA5};
        send_frame(1'b0);
        chk("t5_sync_clears_err", 32'(bus.load_err), 32'd0);
        fr = '{8'h10};
        send_frame(1'b0);
        chk("t5_err_after_len", 32'(bus.load_err), 32'd1);
        fr = '{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(1'b0);
        idle(3);
        chk_status("t5_ignored", 1'b1, 1'b1, 0);
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        push_good1();
        send_frame(1'b0);
        idle(3);
        chk_status("t5_recover", 1'b0, 1'b0, 2);

        // 6: asynchronous reset mid-frame
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34};
        exp_wr.push_back('{wa: 4'd0, din: 16'h1234});
        send_frame(1'b0);
        idle(1);
        chk("t6_hold_before", 32'(bus.cpu_hold), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_wen",  32'(bus.iram_wen), 32'd0);
        chk("t6_wa",   32'(bus.iram_wa),  32'd0);
        chk("t6_din",  32'(bus.iram_din), 32'd0);
        chk("t6_done", 32'(bus.load_done), 32'd0);
        chk_status("t6_rst", 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        push_good1();
        send_frame(1'b0);
        idle(3);
        chk_status("t6_after", 1'b0, 1'b0, 2);

        chk("left_writes", 32'(exp_wr.size()), 32'd0);
        chk("left_dones",  32'(exp_done.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
